// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall arbiter and exception freeze/flush/drain sequencer.
// Optional perf counters are built only when CTRL_PERF_EN is defined.
//
// Ports:
//   clk, rst (async, active-low)
//   stallreq_from_id/ex/mem : stall requests, priority MEM > EX > ID
//   excepttype_i            : MEM-stage exception code, 0 = none
//   cp0_epc_i               : EPC used as the eret target
//   stall[5:0]              : hold bits {WB,MEM,EX,ID,IF,PC}
//   flush, new_pc           : one-cycle flush pulse and its redirect address
//   stall_cycles            : cycles with stall[0]=1 (0 unless CTRL_PERF_EN)
//   flush_count             : flush pulses issued (0 unless CTRL_PERF_EN)
module pipe_ctrl #(
    parameter logic [31:0] EXC_BASE     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_flush;
    logic [31:0] r_new_pc;

    logic        w_exc;
    logic [5:0]  w_arb;
    logic [5:0]  w_stall;
    logic [31:0] w_vec;

    assign w_exc = |excepttype_i;

    always_comb begin
        w_arb = 6'b000000;
        if (stallreq_from_mem)
            w_arb = 6'b011111;
        else if (stallreq_from_ex)
            w_arb = 6'b001111;
        else if (stallreq_from_id)
            w_arb = 6'b000111;
    end

    always_comb begin
        w_vec = EXC_BASE + 32'h40;
        case (excepttype_i)
            32'h1:   w_vec = EXC_BASE + 32'h20;
            32'he:   w_vec = cp0_epc_i;
            default: w_vec = EXC_BASE + 32'h40;
        endcase
    end

    // Stall is forced low during reset so every output reads 0 at once.
    always_comb begin
        w_stall = w_arb;
        if (!rst)
            w_stall = 6'b000000;
        else if (r_state == FLUSH)
            w_stall = 6'b000000;
        else if (r_state == RUN && w_exc)
            w_stall = 6'b111111;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_cnt    <= 4'd0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'h0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_exc) begin
                        r_state  <= FLUSH;
                        r_flush  <= 1'b1;
                        r_new_pc <= w_vec;
                    end
                end
                FLUSH: begin
                    r_flush <= 1'b0;
                    r_cnt   <= 4'(DRAIN_CYCLES);
                    if (DRAIN_CYCLES == 0)
                        r_state <= RUN;
                    else
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1)
                        r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign stall  = w_stall;
    assign flush  = r_flush;
    assign new_pc = r_new_pc;

`ifdef CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'h0;
            r_flush_count  <= 16'h0;
        end else begin
            if (w_stall[0])
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (r_state == FLUSH)
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'h0;
    assign flush_count  = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl.
// Default parameters: EXC_BASE=0, DRAIN_CYCLES=2.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int total;
    int bad;

    pipe_ctrl #(
        .EXC_BASE     (32'h0),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .excepttype_i      (excepttype_i),
        .cp0_epc_i         (cp0_epc_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        stallreq_from_id  = 1'b0;
        stallreq_from_ex  = 1'b0;
        stallreq_from_mem = 1'b0;
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
        #1;
        check("rst_stall",  {26'h0, stall}, 32'h0);
        check("rst_flush",  {31'h0, flush}, 32'h0);
        check("rst_new_pc", new_pc, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        step();
        check("run_flush", {31'h0, flush}, 32'h0);
        check("run_stall", {26'h0, stall}, 32'h0);

        // stall priority
        stallreq_from_id  = 1'b1;
        stallreq_from_ex  = 1'b1;
        stallreq_from_mem = 1'b1;
        settle();
        check("prio_all", {26'h0, stall}, 32'h1f);
        stallreq_from_mem = 1'b0;
        settle();
        check("prio_ex", {26'h0, stall}, 32'h0f);
        stallreq_from_ex = 1'b0;
        settle();
        check("prio_id", {26'h0, stall}, 32'h07);
        stallreq_from_id = 1'b0;
        settle();
        check("prio_none", {26'h0, stall}, 32'h0);

        // exception 8, drain, repeat rejection
        step();
        excepttype_i = 32'h8;
        settle();
        check("exc8_N_stall", {26'h0, stall}, 32'h3f);
        step();
        excepttype_i = 32'h0;
        settle();
        check("exc8_N1_flush", {31'h0, flush}, 32'h1);
        check("exc8_N1_pc",    new_pc, 32'h40);
        check("exc8_N1_stall", {26'h0, stall}, 32'h0);
        step();
        check("exc8_N2_flush", {31'h0, flush}, 32'h0);
        step();
        excepttype_i = 32'h8;
        settle();
        check("exc8_N3_flush", {31'h0, flush}, 32'h0);
        check("exc8_N3_ign",   {26'h0, stall}, 32'h0);
        step();
        check("exc8_N4_acc", {26'h0, stall}, 32'h3f);
        step();
        excepttype_i = 32'h0;
        settle();
        check("exc8_N5_flush", {31'h0, flush}, 32'h1);
        check("exc8_N5_pc",    new_pc, 32'h40);
        step();
        step();
        step();

        // eret
        excepttype_i = 32'he;
        cp0_epc_i    = 32'hBFC0_0100;
        step();
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
        settle();
        check("eret_flush", {31'h0, flush}, 32'h1);
        check("eret_pc",    new_pc, 32'hBFC0_0100);
        step();
        step();
        step();

        // interrupt
        excepttype_i = 32'h1;
        step();
        excepttype_i = 32'h0;
        settle();
        check("int_flush", {31'h0, flush}, 32'h1);
        check("int_pc",    new_pc, 32'h20);
        step();
        check("int_pc_held", new_pc, 32'h20);
        step();
        step();

        // exception coincident with EX stall held 5 cycles
        excepttype_i     = 32'h8;
        stallreq_from_ex = 1'b1;
        settle();
        check("co_N_stall", {26'h0, stall}, 32'h3f);
        step();
        excepttype_i = 32'h0;
        settle();
        check("co_N1_stall", {26'h0, stall}, 32'h0);
        check("co_N1_flush", {31'h0, flush}, 32'h1);
        step();
        check("co_N2_stall", {26'h0, stall}, 32'h0f);
        step();
        check("co_N3_stall", {26'h0, stall}, 32'h0f);
        step();
        check("co_N4_stall", {26'h0, stall}, 32'h0f);
        step();
        stallreq_from_ex = 1'b0;
        settle();
        check("co_drop", {26'h0, stall}, 32'h0);

        // reset in the middle of DRAIN
        excepttype_i = 32'h9;
        step();
        excepttype_i = 32'h0;
        step();
        stallreq_from_ex = 1'b1;
        settle();
        check("mid_drain_stall", {26'h0, stall}, 32'h0f);
        rst = 1'b0;
        #1;
        check("arst_stall",  {26'h0, stall}, 32'h0);
        check("arst_flush",  {31'h0, flush}, 32'h0);
        check("arst_new_pc", new_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_flush", {31'h0, flush}, 32'h0);
        stallreq_from_ex = 1'b0;
        excepttype_i     = 32'h8;
        settle();
        check("post_rst_acc", {26'h0, stall}, 32'h3f);
        step();
        excepttype_i = 32'h0;
        settle();
        check("post_rst_flush1", {31'h0, flush}, 32'h1);
        step();
        step();
        step();

        // perf counters: 7 stall cycles + 2 exceptions
        rst = 1'b0;
        #1;
        check("perf_rst_sc", stall_cycles, 32'h0);
        check("perf_rst_fc", {16'h0, flush_count}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        stallreq_from_id = 1'b1;
        for (int i = 0; i < 7; i++)
            step();
        stallreq_from_id = 1'b0;
        for (int k = 0; k < 2; k++) begin
            excepttype_i = 32'hc;
            step();
            excepttype_i = 32'h0;
            step();
            step();
            step();
        end
`ifdef CTRL_PERF_EN
        check("perf_sc", stall_cycles, 32'd9);
        check("perf_fc", {16'h0, flush_count}, 32'd2);
`else
        check("perf_sc", stall_cycles, 32'd0);
        check("perf_fc", {16'h0, flush_count}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
